// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: MIPS funct codes and the top-level FSM states.
package alu_pkg;

  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MULTU = 6'd25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multu_seq.sv
// Shift-add unsigned multiplier: one iteration per clock, WIDTH iterations per product.
// o_done/o_product are combinational during the last iteration so the caller can latch the result on that edge.
module multu_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW-1:0]     r_count;
  logic               r_busy;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;

  // The carry out of the upper-half add becomes the new MSB after the right shift.
  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign o_product = {w_sum, r_acc[WIDTH-1:1]};
  assign o_done    = r_busy && (r_count == LAST);
  assign o_busy    = r_busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= o_product;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
      if (r_count == LAST) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_n.sv
// N-bit EX-stage ALU: single-cycle AND/OR/ADD/SUB/SLT/SRL plus multi-cycle MULTU into HI/LO.
// Define ALU_SEQ_OVF_EN to build signed-overflow detection for ADD/SUB; otherwise overflow is tied low.
module alu_seq_n
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [5:0]       signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_t           r_state;
  logic             r_busy, r_out_valid, r_zero, r_ovf, r_illegal;
  logic [WIDTH-1:0] r_dout, r_hi, r_lo;

  logic               w_accept, w_start, w_mul_busy, w_mul_done, w_ovf, w_illegal;
  logic [WIDTH-1:0]   w_sum, w_diff, w_result;
  logic [2*WIDTH-1:0] w_product;

  assign w_accept = (r_state == ST_IDLE) && in_valid && !r_busy && !w_mul_busy;
  assign w_start  = w_accept && (signal == FN_MULTU);
  assign w_sum    = dataA + dataB;
  assign w_diff   = dataA + ~dataB + WIDTH'(1);

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (signal)
      FN_AND:   w_result = dataA & dataB;
      FN_OR:    w_result = dataA | dataB;
      FN_ADD:   w_result = w_sum;
      FN_SUB:   w_result = w_diff;
      // Direct signed compare stays correct when A-B overflows.
      FN_SLT:   w_result = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      FN_SRL:   w_result = dataA >> dataB[SHW-1:0];
      FN_MULTU: w_result = '0;
      default:  w_illegal = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_OVF_EN
  always_comb begin
    w_ovf = 1'b0;
    if (signal == FN_ADD)
      w_ovf = (dataA[WIDTH-1] == dataB[WIDTH-1]) && (w_sum[WIDTH-1] != dataA[WIDTH-1]);
    else if (signal == FN_SUB)
      w_ovf = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (w_diff[WIDTH-1] != dataA[WIDTH-1]);
  end
`else
  assign w_ovf = 1'b0;
`endif

  multu_seq #(.WIDTH(WIDTH)) u_multu (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_a       (dataA),
    .i_b       (dataB),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // busy stays high through DONE so no request is taken on the out_valid cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_out_valid <= 1'b0;
          if (w_accept) begin
            if (signal == FN_MULTU) begin
              r_state <= ST_MUL;
              r_busy  <= 1'b1;
            end else begin
              r_out_valid <= 1'b1;
              r_dout      <= w_result;
              r_zero      <= (w_result == '0);
              r_ovf       <= w_ovf;
              r_illegal   <= w_illegal;
            end
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_hi        <= w_product[2*WIDTH-1:WIDTH];
            r_lo        <= w_product[WIDTH-1:0];
            r_dout      <= w_product[WIDTH-1:0];
            r_zero      <= (w_product[WIDTH-1:0] == '0);
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign dataOut   = r_dout;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign zero      = r_zero;
  assign overflow  = r_ovf;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq_n.sv
// Bench for alu_seq_n at WIDTH=32: directed cases plus randomized ops against an arithmetic reference model.
// Expected overflow follows ALU_SEQ_OVF_EN when the bench is compiled with the same define.
module tb_alu_seq_n;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
`ifdef ALU_SEQ_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  sig = 6'd0;
  logic [31:0] a_in = '0, b_in = '0;
  logic        busy, out_valid, zero, overflow, illegal;
  logic [31:0] dout, hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_dout = '0, exp_hi = '0, exp_lo = '0;

  alu_seq_n #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .signal    (sig),
    .dataA     (a_in),
    .dataB     (b_in),
    .busy      (busy),
    .out_valid (out_valid),
    .dataOut   (dout),
    .hi        (hi),
    .lo        (lo),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'd36 || op == 6'd37 || op == 6'd32 || op == 6'd34 ||
           op == 6'd42 || op == 6'd2  || op == 6'd25;
  endfunction

  function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd32:   return a + b;
      6'd34:   return a - b;
      6'd42:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd2:    return a >> (b % 32);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 6'd32)      r = sa + sb;
    else if (op == 6'd34) r = sa - sb;
    else                  r = 0;
    return OVF_ON && (r > SMAX || r < SMIN);
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h7FFFFFFF;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      4: return 32'(int'($urandom_range(0, 40)));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = ref_result(op, a, b);
    in_valid = 1'b1; sig = op; a_in = a; b_in = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check($sformatf("op%0d_valid", op), 64'(out_valid), 64'd1);
    check($sformatf("op%0d_dout", op), 64'(dout), 64'(r));
    check($sformatf("op%0d_zero", op), 64'(zero), 64'(r == 32'd0));
    check($sformatf("op%0d_ovf", op), 64'(overflow), 64'(ref_ovf(op, a, b)));
    check($sformatf("op%0d_illegal", op), 64'(illegal), 64'(!is_legal(op)));
    check($sformatf("op%0d_hilo", op), {hi, lo}, {exp_hi, exp_lo});
    exp_dout = r;
    $display("op=%0d a=%h b=%h -> dout=%h", op, a, b, dout);
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit inject_add);
    logic [63:0] prod;
    int n;
    prod = {32'd0, a} * {32'd0, b};
    in_valid = 1'b1; sig = 6'd25; a_in = a; b_in = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mul_busy_start", 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 100) begin
      if (inject_add && n == 5) begin
        in_valid = 1'b1; sig = 6'd32; a_in = 32'd3; b_in = 32'd4;
      end
      @(posedge clk); #1;
      n++;
    end
    check("mul_latency", 64'(n), 64'd32);
    exp_hi = prod[63:32];
    exp_lo = prod[31:0];
    exp_dout = prod[31:0];
    check("mul_hilo", {hi, lo}, prod);
    check("mul_dout", 64'(dout), 64'(prod[31:0]));
    check("mul_flags", {61'd0, zero, overflow, illegal}, {61'd0, prod[31:0] == 32'd0, 1'b0, 1'b0});
    $display("op=25 a=%h b=%h -> hi=%h lo=%h cycles=%0d", a, b, hi, lo, n);
    @(posedge clk); #1;
    check("mul_done_valid", 64'(out_valid), 64'd0);
    check("mul_done_busy", 64'(busy), 64'd0);
    if (inject_add) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("add_after_mul_valid", 64'(out_valid), 64'd1);
      check("add_after_mul_dout", 64'(dout), 64'd7);
      exp_dout = 32'd7;
      $display("op=32 a=3 b=4 after multu -> dout=%h", dout);
    end
  endtask

  task automatic idle_hold(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
    check("hold_valid", 64'(out_valid), 64'd0);
    check("hold_dout", 64'(dout), 64'(exp_dout));
    check("hold_hilo", {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    int pulses;
    ops = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2};

    // Reset held for two edges clears everything.
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {busy, out_valid, zero, overflow, illegal, dout, hi, lo}, 101'd0);
    rst_n = 1'b1;
    $display("reset released");

    // Directed single-cycle cases.
    do_op(6'd32, 32'h7FFFFFFF, 32'h00000001);
    check("add_const", 64'(dout), 64'h80000000);
    do_op(6'd34, 32'd5, 32'd5);
    check("sub_zero_const", 64'(zero), 64'd1);
    do_op(6'd42, 32'hFFFFFFFF, 32'd1);
    do_op(6'd42, 32'h80000000, 32'h7FFFFFFF);
    check("slt_ovf_const", 64'(dout), 64'd1);
    do_op(6'd2, 32'h80000000, 32'd4);
    do_op(6'd2, 32'h80000000, 32'h24);
    check("srl_shamt_const", 64'(dout), 64'h08000000);
    do_op(6'd34, 32'h80000000, 32'd1);
    do_op(6'd63, 32'h12345678, 32'h9ABCDEF0);
    do_op(6'd36, 32'hF0F0F0F0, 32'hFF00FF00);
    do_op(6'd37, 32'hF0F0F0F0, 32'h0F0F0F0F);
    idle_hold(3);

    // MULTU with requests dropped during busy and on the out_valid cycle.
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    check("mul_max_hi", 64'(hi), 64'hFFFFFFFE);
    idle_hold(2);

    // Reset partway through a MULTU aborts it.
    in_valid = 1'b1; sig = 6'd25; a_in = 32'd12345; b_in = 32'd678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_outs", {busy, out_valid, dout, hi, lo}, 98'd0);
    exp_dout = '0; exp_hi = '0; exp_lo = '0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy) pulses++;
    end
    check("abort_no_result", 64'(pulses), 64'd0);
    $display("multu aborted by reset");

    // Randomized traffic, single-cycle ops back to back.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        6: begin
          do op = 6'($urandom_range(0, 63)); while (is_legal(op));
          do_op(op, rnd_val(), rnd_val());
        end
        7: do_mul(rnd_val(), rnd_val(), 1'b0);
        8: idle_hold(int'($urandom_range(1, 3)));
        default: do_op(ops[$urandom_range(0, 5)], rnd_val(), rnd_val());
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
